// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  localparam int STAGES = WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // Per-stage state: valid bit, operand skew (a, b already inverted for subtract),
  // partially built sum, and the carry out of the group this stage just computed.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             adv;
  int               kp;
  logic [WIDTH-1:0] ga, gb, gs;
  logic             gc, gv;
  logic [BLOCK+1:0] gres;

  // One lookahead group: every carry is a flat sum of generate/propagate products,
  // so no carry ripples inside the group. Returns {carry into MSB, carry out, sum}.
  function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] ga_i,
                                                 input logic [BLOCK-1:0] gb_i,
                                                 input logic             gc_i);
    logic [BLOCK-1:0] p, g;
    logic [BLOCK:0]   c;
    logic             term;
    p    = ga_i ^ gb_i;
    g    = ga_i & gb_i;
    c    = '0;
    c[0] = gc_i;
    for (int i = 0; i < BLOCK; i++) begin
      term = gc_i;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  // The whole pipe moves as one: it advances unless a finished result is being held.
  always_comb begin
    adv = !valid_q[STAGES-1] | out_ready;
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry_out = carry_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Stage k takes group k from the previous stage's skewed operands and carry.
  always_comb begin
    ga     = '0;
    gb     = '0;
    gs     = '0;
    gc     = 1'b0;
    gv     = 1'b0;
    gres   = '0;
    kp     = 0;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      opa_d[k]   = opa_q[k];
      opb_d[k]   = opb_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
    end
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        kp = (k == 0) ? 0 : k - 1;
        if (k == 0) begin
          ga = a;
          gb = sub ? ~b : b;
          gc = sub | cin;
          gs = '0;
          gv = in_valid;
        end else begin
          ga = opa_q[kp];
          gb = opb_q[kp];
          gc = carry_q[kp];
          gs = sum_q[kp];
          gv = valid_q[kp];
        end
        gres = cla_group(ga[k*BLOCK +: BLOCK], gb[k*BLOCK +: BLOCK], gc);
        gs[k*BLOCK +: BLOCK] = gres[BLOCK-1:0];
        valid_d[k] = gv;
        opa_d[k]   = ga;
        opb_d[k]   = gb;
        sum_d[k]   = gs;
        carry_d[k] = gres[BLOCK];
        if (k == STAGES - 1) begin
          ovf_d  = gres[BLOCK+1] ^ gres[BLOCK];
          zero_d = (gs == '0);
        end
      end
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - self-checking bench for cla_pipe_addsub
module tb_cla_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        sub, cin;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        carry_out, overflow, zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  // Sweep instances: 8/8, 16/4, 64/16
  logic [2:0]  sw_in_valid, sw_out_ready, sw_sub, sw_cin;
  wire  [2:0]  sw_in_ready, sw_out_valid, sw_co, sw_ov, sw_z;
  logic [63:0] sw_a [3];
  logic [63:0] sw_b [3];
  wire  [63:0] sw_sum [3];
  wire  [7:0]  s8_sum;
  wire  [15:0] s16_sum;
  wire  [63:0] s64_sum;
  assign sw_sum[0] = {56'd0, s8_sum};
  assign sw_sum[1] = {48'd0, s16_sum};
  assign sw_sum[2] = s64_sum;

  cla_pipe_addsub #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .a(sw_a[0][7:0]), .b(sw_b[0][7:0]), .sub(sw_sub[0]), .cin(sw_cin[0]),
    .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]),
    .sum(s8_sum), .carry_out(sw_co[0]), .overflow(sw_ov[0]), .zero(sw_z[0])
  );
  cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .a(sw_a[1][15:0]), .b(sw_b[1][15:0]), .sub(sw_sub[1]), .cin(sw_cin[1]),
    .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]),
    .sum(s16_sum), .carry_out(sw_co[1]), .overflow(sw_ov[1]), .zero(sw_z[1])
  );
  cla_pipe_addsub #(.WIDTH(64), .BLOCK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .a(sw_a[2]), .b(sw_b[2]), .sub(sw_sub[2]), .cin(sw_cin[2]),
    .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]),
    .sum(s64_sum), .carry_out(sw_co[2]), .overflow(sw_ov[2]), .zero(sw_z[2])
  );

  // Reference: plain wide addition, overflow from operand/result sign rule. {zero, ovf, cout, sum}
  function automatic logic [66:0] ref_op(input logic [63:0] ra, input logic [63:0] rb,
                                         input logic rsub, input logic rcin, input int w);
    logic [63:0] m, aa, bb, s;
    logic [64:0] full;
    logic        co, ov;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = ra & m;
    bb   = (rsub ? ~rb : rb) & m;
    full = {1'b0, aa} + {1'b0, bb} + (rsub ? 65'd1 : {64'd0, rcin});
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {(s == 64'd0), ov, co, s};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'h1234; b = 32'h1; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (sum !== 32'd0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
    total++; if ({carry_out, overflow, zero} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {carry_out, overflow, zero}); end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_capture: cycle %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic        ts [6];
    logic        tc [6];
    logic [31:0] es [6];
    logic [2:0]  ef [6];   // {carry_out, overflow, zero}
    int lat;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'h1; ts[0] = 0; tc[0] = 0; es[0] = 32'h0;        ef[0] = 3'b101;
    ta[1] = 32'h7FFFFFFF; tb[1] = 32'h1; ts[1] = 0; tc[1] = 0; es[1] = 32'h80000000; ef[1] = 3'b010;
    ta[2] = 32'h80000000; tb[2] = 32'h1; ts[2] = 1; tc[2] = 0; es[2] = 32'h7FFFFFFF; ef[2] = 3'b110;
    ta[3] = 32'h5;        tb[3] = 32'h7; ts[3] = 1; tc[3] = 0; es[3] = 32'hFFFFFFFE; ef[3] = 3'b000;
    ta[4] = 32'h1;        tb[4] = 32'h1; ts[4] = 0; tc[4] = 1; es[4] = 32'h3;        ef[4] = 3'b000;
    ta[5] = 32'h9;        tb[5] = 32'h4; ts[5] = 1; tc[5] = 1; es[5] = 32'h5;        ef[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[i]; b = tb[i]; sub = ts[i]; cin = tc[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      total++; if (lat != 4) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
      total++; if (sum !== es[i]) begin bad++; $display("FAIL directed_sum[%0d]: got %h want %h", i, sum, es[i]); end
      total++; if ({carry_out, overflow, zero} !== ef[i]) begin bad++; $display("FAIL directed_flags[%0d]: got %b want %b", i, {carry_out, overflow, zero}, ef[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [66:0] q[$];
    logic [66:0] e;
    int sent = 0, got = 0, stall_left = 0, guard = 0;
    bit first_seen = 0, need_new = 1;
    while ((sent < 10 || q.size() > 0) && guard < 80) begin
      @(negedge clk);
      guard++;
      if (need_new) begin
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        need_new = 0;
      end
      in_valid  = (sent < 10);
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL bp_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra_result: got %h want none", sum);
        end else begin
          e = q.pop_front();
          got++;
          if ({zero, overflow, carry_out, 32'd0, sum} !== e) begin
            bad++; $display("FAIL bp_result[%0d]: got %h want %h", got, {zero, overflow, carry_out, 32'd0, sum}, e);
          end
        end
        if (!first_seen) begin first_seen = 1; stall_left = 3; end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op({32'd0, a}, {32'd0, b}, sub, cin, 32));
        sent++;
        need_new = 1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 10) begin bad++; $display("FAIL bp_count: got %0d want 10", got); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h3; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d]: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1; a = 32'h10; b = 32'h20; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    total++; if ({sum, carry_out, overflow, zero} !== {32'h30, 3'b000}) begin
      bad++; $display("FAIL midrst_result: got %h want %h", {sum, carry_out, overflow, zero}, {32'h30, 3'b000});
    end
  endtask

  task automatic test_sweep(input int s, input int w, input int st);
    logic [66:0] q[$];
    logic [66:0] e, g;
    int sent = 0, lat, guard = 0;
    @(negedge clk);
    sw_a[s] = {$urandom, $urandom}; sw_b[s] = {$urandom, $urandom};
    sw_sub[s] = 1'b0; sw_cin[s] = 1'b1; sw_in_valid[s] = 1'b1; sw_out_ready[s] = 1'b1;
    e = ref_op(sw_a[s], sw_b[s], 1'b0, 1'b1, w);
    @(negedge clk);
    sw_in_valid[s] = 1'b0;
    lat = 1;
    while (!sw_out_valid[s] && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != st) begin bad++; $display("FAIL sweep%0d_latency: got %0d want %0d", w, lat, st); end
    g = {sw_z[s], sw_ov[s], sw_co[s], sw_sum[s]};
    total++; if (g !== e) begin bad++; $display("FAIL sweep%0d_first: got %h want %h", w, g, e); end
    while ((sent < 1000 || q.size() > 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      sw_a[s] = {$urandom, $urandom}; sw_b[s] = {$urandom, $urandom};
      sw_sub[s] = 1'($urandom_range(0, 1)); sw_cin[s] = 1'($urandom_range(0, 1));
      sw_in_valid[s]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      sw_out_ready[s] = ($urandom_range(0, 2) != 0);
      #1;
      if (sw_out_valid[s] && sw_out_ready[s]) begin
        total++;
        g = {sw_z[s], sw_ov[s], sw_co[s], sw_sum[s]};
        if (q.size() == 0) begin
          bad++; $display("FAIL sweep%0d_extra: got %h want none", w, g);
        end else begin
          e = q.pop_front();
          if (g !== e) begin bad++; $display("FAIL sweep%0d_result: got %h want %h", w, g, e); end
        end
      end
      if (sw_in_valid[s] && sw_in_ready[s]) begin
        q.push_back(ref_op(sw_a[s], sw_b[s], sw_sub[s], sw_cin[s], w));
        sent++;
      end
    end
    sw_in_valid[s] = 1'b0; sw_out_ready[s] = 1'b1;
    total++; if (sent != 1000 || q.size() != 0) begin
      bad++; $display("FAIL sweep%0d_drain: got sent=%0d pending=%0d want 1000/0", w, sent, q.size());
    end
  endtask

  initial begin
    sw_in_valid = '0; sw_out_ready = '1; sw_sub = '0; sw_cin = '0;
    for (int i = 0; i < 3; i++) begin sw_a[i] = '0; sw_b[i] = '0; end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_sweep(0, 8, 1);
    test_sweep(1, 16, 4);
    test_sweep(2, 64, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. Operands of `WIDTH` bits are split into `BLOCK`-bit lookahead groups; each group is computed in its own pipeline stage, and the group carry is registered forward to the next stage. The block accepts one operation per cycle under a valid/ready handshake. It returns the sum with carry, signed-overflow and zero flags. It replaces the fixed 8-bit combinational adder as the ALU arithmetic unit.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `BLOCK`.
- `BLOCK`, 8, lookahead group width in bits (one group per stage).
- `STAGES`, `WIDTH/BLOCK`, derived stage count; not overridden.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  1 = A − B, 0 = A + B.
- `cin`  in  1  carry-in for add mode; ignored when `sub`=1.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `carry_out`  out  1  carry out of MSB; in subtract mode 1 = no borrow (A ≥ B unsigned).
- `overflow`  out  1  signed two's-complement overflow.
- `zero`  out  1  `sum` == 0.

## Operation
- Preprocessing at input: `b_eff = sub ? ~b : b`, `c0 = sub ? 1 : cin`.
- Per group: `P = a ^ b_eff`, `G = a & b_eff`. Group carries are computed by lookahead: c[i+1] = G[i] | P[i]&c[i], expanded, with no ripple inside the group. `S = P ^ C`.
- Stage k (0..STAGES−1) computes group k using the carry registered by stage k−1; stage 0 uses `c0`.
- Operand groups not yet consumed, and completed sum groups, are carried along in skew registers so each beat exits aligned.
- Final stage registers `sum`, `carry_out` = carry out of the top group, `overflow` = carry into MSB XOR carry out of MSB, and `zero`.
- Each stage holds a valid bit. A global advance enable is `adv = !out_valid | out_ready`. When `adv`=0, all stage registers hold.
- `in_ready = adv`. A beat is accepted when `in_valid & in_ready`. Bubbles travel as invalid stages and are not collapsed.
- Results emerge strictly in acceptance order. There is no drop and no duplication.

## Timing
- Latency: `STAGES` cycles from acceptance edge to `out_valid` high, with no stall. Default is 4.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `out_valid` and the flags are registered outputs. `sum` and the flags are stable while `out_valid & !out_ready`.
- `in_ready` is combinational from `out_ready` and `out_valid`. `in_ready` is 1 whenever the output stage is empty.
- Simultaneous accept and output handshake in the same cycle: both occur and the pipeline advances by one.
- Reset (async assert, any time): all stage valid bits are cleared, `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0, `zero`=0. In-flight beats are discarded.
- `in_ready`=1 while in reset, because `out_valid`=0. Beats offered during reset are not captured. Capture starts on the first rising edge after deassert.
- Reset deassert is synchronised externally. The block makes no metastability guarantees on `rst` release.
- `WIDTH=BLOCK` degenerates to a single registered stage with latency 1.

## Test plan
- Add wrap: `a`=0xFFFFFFFF, `b`=1, `sub`=0, `cin`=0 -> 4 cycles later `sum`=0, `carry_out`=1, `zero`=1, `overflow`=0.
- Signed overflow: `a`=0x7FFFFFFF, `b`=1 add -> `sum`=0x80000000, `overflow`=1, `carry_out`=0. Also `a`=0x80000000, `b`=1, `sub`=1 -> `sum`=0x7FFFFFFF, `overflow`=1, `carry_out`=1.
- Subtract borrow and carry-in: 5−7 -> `sum`=0xFFFFFFFE, `carry_out`=0, `overflow`=0. Add 1+1 with `cin`=1 -> `sum`=3. Sub with `cin`=1, 9−4 -> `sum`=5 (`cin` ignored).
- Backpressure: stream 10 random beats back-to-back, and drop `out_ready` for 3 cycles after the first result -> `in_ready`=0 exactly while `out_valid & !out_ready`. All 10 results match the model, in order, with none lost or repeated.
- Reset mid-stream: accept 3 beats, then assert `rst` for 1 cycle before any result -> `out_valid` drops immediately and stays 0. No stale result appears in the following 6 cycles. The next accepted beat returns after exactly 4 cycles.
- Parameter sweep: `WIDTH`/`BLOCK` = 8/8, 16/4, 64/16 with 1000 random beats each and random `out_ready` -> bit-exact match to the reference model, with latency equal to `STAGES`.
